// File: rtl/dsram_req_ctrl.sv
// Data-side SRAM-like bus sequencer between EX and MEM: issues one access at a time,
// stalls the pipe until it completes, and drains flushed accesses. Optional macro: DSRAM_PERF_EN.
module dsram_req_ctrl #(
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              pipe_stall,
    input  logic              req_en,
    input  logic [3:0]        req_wen,
    input  logic [1:0]        req_size,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stallreq,
    output logic [31:0]       rdata_o,
    output logic              rdata_valid,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [31:0]       data_addr,
    output logic [31:0]       data_wdata,
    output logic [3:0]        data_wstrb,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [31:0]       data_rdata
`ifdef DSRAM_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_stall_cnt
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    logic        cancel_r;
    logic        cancel_nxt_s;
    logic [3:0]  wen_r;
    logic [1:0]  size_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [31:0] buf_r;
    logic        issue_s;
    logic        buf_load_s;
    logic        stall_base_s;

    // Elaboration-only guard on the counter width; it is empty for any legal PERF_W.
    if (PERF_W < 1) begin : g_perf_w_check
    end

    // Next-state, bus drive and pipeline handshake decode.
    always_comb begin
        state_nxt_s  = state_r;
        cancel_nxt_s = cancel_r;
        issue_s      = 1'b0;
        buf_load_s   = 1'b0;
        data_req     = 1'b0;
        stall_base_s = 1'b0;
        rdata_valid  = 1'b0;
        rdata_o      = 32'h0000_0000;
        data_wr      = |wen_r;
        data_size    = size_r;
        data_addr    = addr_r;
        data_wdata   = wdata_r;
        data_wstrb   = wen_r;
        case (state_r)
            ST_IDLE: begin
                data_wr      = |req_wen;
                data_size    = req_size;
                data_addr    = req_addr;
                data_wdata   = req_wdata;
                data_wstrb   = req_wen;
                issue_s      = req_en & ~flush & ~cancel_r;
                data_req     = issue_s;
                stall_base_s = issue_s;
                if (issue_s) begin
                    state_nxt_s = data_addr_ok ? ST_WAIT : ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                // The request stays up until accepted; a flush only marks it for draining.
                data_req     = 1'b1;
                stall_base_s = 1'b1;
                if (flush) begin
                    cancel_nxt_s = 1'b1;
                end else begin
                    cancel_nxt_s = cancel_r;
                end
                if (data_addr_ok) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                stall_base_s = ~data_data_ok;
                if (data_data_ok) begin
                    if (cancel_r | flush) begin
                        cancel_nxt_s = 1'b0;
                        state_nxt_s  = ST_IDLE;
                    end else if (!pipe_stall) begin
                        rdata_valid = 1'b1;
                        rdata_o     = data_rdata;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        buf_load_s  = 1'b1;
                        state_nxt_s = ST_HOLD;
                    end
                end else begin
                    if (flush) begin
                        cancel_nxt_s = 1'b1;
                    end else begin
                        cancel_nxt_s = cancel_r;
                    end
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                rdata_o = buf_r;
                if (flush) begin
                    state_nxt_s = ST_IDLE;
                end else if (!pipe_stall) begin
                    rdata_valid = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s  = ST_IDLE;
                cancel_nxt_s = 1'b0;
            end
        endcase
        // While a flushed access drains, only a live new instruction needs holding.
        stallreq = cancel_r ? (req_en & ~flush) : stall_base_s;
    end

    // State, drain flag, request copy and read-data buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cancel_r <= 1'b0;
            wen_r    <= 4'h0;
            size_r   <= 2'd0;
            addr_r   <= 32'h0000_0000;
            wdata_r  <= 32'h0000_0000;
            buf_r    <= 32'h0000_0000;
        end else begin
            state_r  <= state_nxt_s;
            cancel_r <= cancel_nxt_s;
            if (issue_s) begin
                wen_r   <= req_wen;
                size_r  <= req_size;
                addr_r  <= req_addr;
                wdata_r <= req_wdata;
            end
            if (buf_load_s) begin
                buf_r <= data_rdata;
            end
        end
    end

`ifdef DSRAM_PERF_EN
    // Free-running count of stalled cycles, wrapping naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= {PERF_W{1'b0}};
        end else if (stallreq) begin
            perf_stall_cnt <= perf_stall_cnt + {{(PERF_W-1){1'b0}}, 1'b1};
        end
    end
`endif

endmodule

// File: tb/tb_dsram_req_ctrl.sv
// Scoreboarded bench for dsram_req_ctrl: expected load data is queued when the bus returns it
// and popped when the controller presents rdata_valid.
module tb_dsram_req_ctrl;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        pipe_stall;
    logic        req_en;
    logic [3:0]  req_wen;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stallreq;
    logic [31:0] rdata_o;
    logic        rdata_valid;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
`ifdef DSRAM_PERF_EN
    logic [31:0] perf_stall_cnt;
`endif

    int          n_vec;
    int          n_err;
    int          hs_cnt;
    logic [31:0] sb_q[$];

    dsram_req_ctrl #(.PERF_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .pipe_stall(pipe_stall),
        .req_en(req_en), .req_wen(req_wen), .req_size(req_size),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stallreq(stallreq), .rdata_o(rdata_o), .rdata_valid(rdata_valid),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
`ifdef DSRAM_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush        = 1'b0;
        pipe_stall   = 1'b0;
        req_en       = 1'b0;
        req_wen      = 4'h0;
        req_size     = 2'd0;
        req_addr     = 32'h0000_0000;
        req_wdata    = 32'h0000_0000;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'h0000_0000;
    endtask

    task automatic issue_load(input logic [31:0] addr, input logic aok);
        req_en       = 1'b1;
        req_wen      = 4'h0;
        req_size     = 2'd2;
        req_addr     = addr;
        data_addr_ok = aok;
    endtask

    // Scoreboard side: pops one expected word per rdata_valid and counts accepted requests.
    always @(negedge clk) begin
        if (!rst) begin
            if (data_req && data_addr_ok) hs_cnt++;
            if (rdata_valid) begin
                if (sb_q.size() == 0) begin
                    check_val("unexp_valid", {31'd0, rdata_valid}, 32'd0);
                end else begin
                    check_val("rdata", rdata_o, sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        n_vec  = 0;
        n_err  = 0;
        hs_cnt = 0;
        rst    = 1'b1;
        idle_inputs();
        next_cycle();
        next_cycle();
        #3;
        check_val("rst_data_req", {31'd0, data_req}, 32'd0);
        check_val("rst_stallreq", {31'd0, stallreq}, 32'd0);
        check_val("rst_valid", {31'd0, rdata_valid}, 32'd0);
        check_val("rst_rdata", rdata_o, 32'h0);
`ifdef DSRAM_PERF_EN
        check_val("rst_perf", perf_stall_cnt, 32'd0);
`endif
        next_cycle();
        rst = 1'b0;

        // zero-wait load
        issue_load(32'h8000_0010, 1'b1);
        #3;
        check_val("zw_req", {31'd0, data_req}, 32'd1);
        check_val("zw_stall0", {31'd0, stallreq}, 32'd1);
        check_val("zw_addr", data_addr, 32'h8000_0010);
        check_val("zw_wr", {31'd0, data_wr}, 32'd0);
        next_cycle();
        idle_inputs();
        data_data_ok = 1'b1;
        data_rdata   = 32'hDEAD_BEEF;
        sb_q.push_back(32'hDEAD_BEEF);
        #3;
        check_val("zw_valid", {31'd0, rdata_valid}, 32'd1);
        check_val("zw_stall1", {31'd0, stallreq}, 32'd0);
`ifdef DSRAM_PERF_EN
        check_val("zw_perf", perf_stall_cnt, 32'd1);
`endif
        next_cycle();
        idle_inputs();

        // addr_ok delayed three cycles; request fields must stay frozen
        issue_load(32'h1000_0004, 1'b0);
        for (int c = 0; c < 4; c++) begin
            if (c > 0) begin
                req_en   = 1'b0;
                req_addr = 32'hFFFF_FFFF;
                req_size = 2'd0;
            end
            data_addr_ok = (c == 3);
            #3;
            check_val("dly_req", {31'd0, data_req}, 32'd1);
            check_val("dly_addr", data_addr, 32'h1000_0004);
            check_val("dly_size", {30'd0, data_size}, 32'd2);
            check_val("dly_stall", {31'd0, stallreq}, 32'd1);
            next_cycle();
        end
        idle_inputs();
        data_data_ok = 1'b1;
        data_rdata   = 32'hCAFE_0001;
        sb_q.push_back(32'hCAFE_0001);
        #3;
        check_val("dly_req_low", {31'd0, data_req}, 32'd0);
        check_val("dly_valid", {31'd0, rdata_valid}, 32'd1);
        next_cycle();
        idle_inputs();

        // data returned while pipe is held
        issue_load(32'h2000_0000, 1'b1);
        next_cycle();
        idle_inputs();
        data_data_ok = 1'b1;
        data_rdata   = 32'h1234_5678;
        pipe_stall   = 1'b1;
        sb_q.push_back(32'h1234_5678);
        #3;
        check_val("hold_valid0", {31'd0, rdata_valid}, 32'd0);
        next_cycle();
        idle_inputs();
        pipe_stall = 1'b1;
        req_en     = 1'b1;
        data_rdata = 32'h0BAD_F00D;
        #3;
        check_val("hold_valid1", {31'd0, rdata_valid}, 32'd0);
        check_val("hold_rdata", rdata_o, 32'h1234_5678);
        check_val("hold_noreq", {31'd0, data_req}, 32'd0);
        check_val("hold_stall", {31'd0, stallreq}, 32'd0);
        next_cycle();
        idle_inputs();
        #3;
        check_val("hold_release", {31'd0, rdata_valid}, 32'd1);
        next_cycle();

        // store
        req_en       = 1'b1;
        req_wen      = 4'b0011;
        req_size     = 2'd1;
        req_addr     = 32'h3000_0002;
        req_wdata    = 32'hAAAA_5555;
        data_addr_ok = 1'b1;
        #3;
        check_val("st_wr", {31'd0, data_wr}, 32'd1);
        check_val("st_wstrb", {28'd0, data_wstrb}, 32'd3);
        check_val("st_wdata", data_wdata, 32'hAAAA_5555);
        check_val("st_size", {30'd0, data_size}, 32'd1);
        next_cycle();
        idle_inputs();
        data_data_ok = 1'b1;
        data_rdata   = 32'h0BAD_0BAD;
        sb_q.push_back(32'h0BAD_0BAD);
        #3;
        check_val("st_valid", {31'd0, rdata_valid}, 32'd1);
        next_cycle();
        idle_inputs();

        // flush while in REQ, with a new instruction waiting for the drain
        issue_load(32'h4000_00A1, 1'b0);
        next_cycle();
        flush    = 1'b1;
        req_addr = 32'h4000_00A2;
        #3;
        check_val("fl_req1", {31'd0, data_req}, 32'd1);
        check_val("fl_addr1", data_addr, 32'h4000_00A1);
        next_cycle();
        flush = 1'b0;
        #3;
        check_val("fl_req2", {31'd0, data_req}, 32'd1);
        check_val("fl_stall2", {31'd0, stallreq}, 32'd1);
        next_cycle();
        data_addr_ok = 1'b1;
        #3;
        check_val("fl_req3", {31'd0, data_req}, 32'd1);
        next_cycle();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = 32'hBADB_AD00;
        #3;
        check_val("fl_drain_valid", {31'd0, rdata_valid}, 32'd0);
        check_val("fl_drain_stall", {31'd0, stallreq}, 32'd1);
        check_val("fl_drain_req", {31'd0, data_req}, 32'd0);
        next_cycle();
        data_data_ok = 1'b0;
        data_addr_ok = 1'b1;
        #3;
        check_val("fl_new_req", {31'd0, data_req}, 32'd1);
        check_val("fl_new_addr", data_addr, 32'h4000_00A2);
        next_cycle();
        idle_inputs();
        data_data_ok = 1'b1;
        data_rdata   = 32'h5566_7788;
        sb_q.push_back(32'h5566_7788);
        next_cycle();
        idle_inputs();

        // flush coincident with data_ok in WAIT
        issue_load(32'h5000_0000, 1'b1);
        next_cycle();
        idle_inputs();
        flush        = 1'b1;
        data_data_ok = 1'b1;
        data_rdata   = 32'h7777_7777;
        #3;
        check_val("fw_valid", {31'd0, rdata_valid}, 32'd0);
        next_cycle();
        idle_inputs();
        #3;
        check_val("fw_idle_req", {31'd0, data_req}, 32'd0);
        next_cycle();

        // flush while held in HOLD
        issue_load(32'h6000_0000, 1'b1);
        next_cycle();
        idle_inputs();
        data_data_ok = 1'b1;
        data_rdata   = 32'h8888_8888;
        pipe_stall   = 1'b1;
        next_cycle();
        idle_inputs();
        pipe_stall = 1'b1;
        flush      = 1'b1;
        #3;
        check_val("fh_valid0", {31'd0, rdata_valid}, 32'd0);
        next_cycle();
        idle_inputs();
        #3;
        check_val("fh_valid1", {31'd0, rdata_valid}, 32'd0);

        // flush in IDLE blocks issue
        req_en = 1'b1;
        flush  = 1'b1;
        #3;
        check_val("fi_req", {31'd0, data_req}, 32'd0);
        check_val("fi_stall", {31'd0, stallreq}, 32'd0);
        next_cycle();
        idle_inputs();

        // reset in the middle of a request
        issue_load(32'h7000_0000, 1'b0);
        next_cycle();
        idle_inputs();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        #3;
        check_val("mid_rst_req", {31'd0, data_req}, 32'd0);
        check_val("mid_rst_stall", {31'd0, stallreq}, 32'd0);
        next_cycle();

        check_val("sb_empty", sb_q.size(), 32'd0);
        check_val("handshakes", hs_cnt, 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
